// File: rtl/cola_pkg.sv
// rtl/cola_pkg.sv - shared defaults and FSM encoding for the cola write arbiter
package cola_pkg;

  localparam int B_DEFAULT = 3;
  localparam int W_DEFAULT = 2;

  typedef enum logic {
    IDLE = 1'b0,
    WR   = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin pick; a lone request always wins,
// contention goes to the requester that was not granted last
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic sel,
  output logic valid
);

  assign valid = req0 | req1;
  assign sel   = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/cola_arbiter.sv
// rtl/cola_arbiter.sv - two-requester round-robin write arbiter for cola_fifo;
// one write per two cycles, all outputs registered
module cola_arbiter
  import cola_pkg::*;
#(
  parameter int B = B_DEFAULT,
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [B-1:0] din0,
  input  logic [B-1:0] din1,
  output logic         gnt0,
  output logic         gnt1,
  input  logic         fifo_full,
  output logic         fifo_wr,
  output logic [B-1:0] fifo_in,
  output logic [7:0]   cnt0,
  output logic [7:0]   cnt1,
  output logic         busy
);

  // W only sizes the downstream fifo; nothing here depends on it
  if (W < 1) begin : g_w_unused
  end

  state_t       state_q, state_d;
  logic         last_q, last_d;
  logic         gnt0_d, gnt1_d, wr_d, busy_d;
  logic [B-1:0] in_d;
  logic [7:0]   cnt0_d, cnt1_d;
  logic         pick_sel, pick_valid;

  rr_pick2 u_pick (
    .req0  (req0),
    .req1  (req1),
    .last  (last_q),
    .sel   (pick_sel),
    .valid (pick_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      fifo_wr <= 1'b0;
      busy    <= 1'b0;
      fifo_in <= '0;
      cnt0    <= 8'd0;
      cnt1    <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt0    <= gnt0_d;
      gnt1    <= gnt1_d;
      fifo_wr <= wr_d;
      busy    <= busy_d;
      fifo_in <= in_d;
      cnt0    <= cnt0_d;
      cnt1    <= cnt1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    wr_d    = 1'b0;
    busy_d  = 1'b0;
    in_d    = fifo_in;
    cnt0_d  = cnt0;
    cnt1_d  = cnt1;
    case (state_q)
      IDLE: begin
        if (!fifo_full && pick_valid) begin
          state_d = WR;
          wr_d    = 1'b1;
          busy_d  = 1'b1;
          gnt0_d  = ~pick_sel;
          gnt1_d  = pick_sel;
          in_d    = pick_sel ? din1 : din0;
          last_d  = pick_sel;
        end
      end
      WR: begin
        // the registered grant identifies whose count to bump as WR ends
        state_d = IDLE;
        if (gnt0 && cnt0 != 8'hFF) cnt0_d = cnt0 + 8'd1;
        if (gnt1 && cnt1 != 8'hFF) cnt1_d = cnt1 + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cola_arbiter.sv
// tb/tb_cola_arbiter.sv - directed self-checking bench for cola_arbiter
module tb_cola_arbiter;

  logic       clk;
  logic       reset;
  logic       req0, req1;
  logic [2:0] din0, din1;
  logic       gnt0, gnt1;
  logic       fifo_full;
  logic       fifo_wr;
  logic [2:0] fifo_in;
  logic [7:0] cnt0, cnt1;
  logic       busy;
  logic       rd;
  int         occ;
  int         n_vec;
  int         n_err;
  int         g0;

  cola_arbiter #(.B(3), .W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .din0      (din0),
    .din1      (din1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .fifo_in   (fifo_in),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // depth-4 fifo occupancy, sharing the arbiter reset
  always @(posedge clk or posedge reset) begin
    if (reset) occ <= 0;
    else occ <= occ + (fifo_wr ? 1 : 0) - ((rd && occ != 0) ? 1 : 0);
  end
  assign fifo_full = (occ == 4);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; g0 = 0;
    clk = 1'b0; reset = 1'b1; rd = 1'b0;
    req0 = 1'b0; req1 = 1'b0; din0 = '0; din1 = '0;
    step();
    step();
    check("rst_wr",   fifo_wr, 0);
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_busy", busy, 0);
    check("rst_in",   fifo_in, 0);
    check("rst_cnt0", cnt0, 0);
    check("rst_cnt1", cnt1, 0);

    // single requester
    reset = 1'b0;
    req0 = 1'b1; din0 = 3'b101;
    step();
    check("single_wr",   fifo_wr, 1);
    check("single_in",   fifo_in, 5);
    check("single_gnt0", gnt0, 1);
    check("single_gnt1", gnt1, 0);
    check("single_busy", busy, 1);
    req0 = 1'b0;
    step();
    check("single_wr_off", fifo_wr, 0);
    check("single_cnt0",   cnt0, 1);
    check("single_hold",   fifo_in, 5);
    check("single_idle",   busy, 0);

    // contention: grants alternate starting with requester 0
    req0 = 1'b1; req1 = 1'b1; din0 = 3'b001; din1 = 3'b110;
    do_reset();
    step();
    check("rr1_gnt0", gnt0, 1); check("rr1_gnt1", gnt1, 0); check("rr1_in", fifo_in, 1);
    step();
    check("rr2_gnt", {gnt0, gnt1}, 0);
    step();
    check("rr3_gnt0", gnt0, 0); check("rr3_gnt1", gnt1, 1); check("rr3_in", fifo_in, 6);
    step();
    check("rr4_gnt", {gnt0, gnt1}, 0);
    step();
    check("rr5_gnt0", gnt0, 1); check("rr5_gnt1", gnt1, 0);
    step();
    step();
    check("rr7_gnt0", gnt0, 0); check("rr7_gnt1", gnt1, 1);
    step();
    check("rr_cnt0", cnt0, 2);
    check("rr_cnt1", cnt1, 2);
    check("rr_full", fifo_full, 1);

    // full fifo blocks requester 1 until a read frees a slot
    req0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("full_wr",   fifo_wr, 0);
      check("full_gnt1", gnt1, 0);
    end
    rd = 1'b1;
    step();
    rd = 1'b0;
    check("full_gnt1_wait", gnt1, 0);
    step();
    check("full_gnt1_go", gnt1, 1);
    check("full_in",      fifo_in, 6);
    req1 = 1'b0;
    step();
    check("full_cnt1", cnt1, 3);

    // reset during WR
    req0 = 1'b1; din0 = 3'b011;
    do_reset();
    step();
    step();
    check("mid_cnt0_pre", cnt0, 1);
    step();
    check("mid_wr_pre", fifo_wr, 1);
    reset = 1'b1;
    #1;
    check("mid_wr",   fifo_wr, 0);
    check("mid_gnt0", gnt0, 0);
    check("mid_busy", busy, 0);
    check("mid_cnt0", cnt0, 0);
    step();
    reset = 1'b0;
    step();
    check("mid_regrant", gnt0, 1);
    check("mid_wr_post", fifo_wr, 1);
    check("mid_in",      fifo_in, 3);
    step();
    check("mid_cnt0_post", cnt0, 1);

    // req1 pulsed only during WR for requester 0
    step();
    check("wd_gnt0", gnt0, 1);
    req1 = 1'b1; din1 = 3'b111;
    step();
    check("wd_gnt1_a", gnt1, 0);
    check("wd_cnt0",   cnt0, 2);
    req0 = 1'b0; req1 = 1'b0;
    step();
    check("wd_gnt1_b", gnt1, 0);
    check("wd_wr",     fifo_wr, 0);
    check("wd_cnt1",   cnt1, 0);

    // saturation: 300 grants to requester 0 with the fifo drained every cycle
    req0 = 1'b1; rd = 1'b1;
    do_reset();
    for (int i = 0; i < 508; i++) begin
      step();
      if (gnt0) g0++;
    end
    check("sat_cnt0_254", cnt0, 254);
    for (int i = 0; i < 92; i++) begin
      step();
      if (gnt0) g0++;
    end
    req0 = 1'b0; rd = 1'b0;
    check("sat_grants", g0, 300);
    check("sat_cnt0",   cnt0, 255);
    check("sat_cnt1",   cnt1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
